// File: rtl/uar_cmd_parser_pkg.sv
// Shared definitions for the host-link command parser: sync marker, error codes,
// FSM state encodings and timer width.
package uar_cmd_parser_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         TIMER_W      = 24;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_ISSUE = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_FRAMING  = 3'd1,
    ERR_TIMEOUT  = 3'd2,
    ERR_CHECKSUM = 3'd3,
    ERR_BAD_CMD  = 3'd4,
    ERR_OVERRUN  = 3'd5
  } err_code_e;

  // States in which a packet is partially collected and the idle-gap timer runs.
  function automatic logic in_packet(input state_e s);
    return (s == S_CMD) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/uar_cmd_parser_byte_timeout.sv
// Idle-gap timer: saturating up-counter that pulses expire while its count sits at LIMIT.
// Held at zero whenever it is cleared or not running.
module uar_cmd_parser_byte_timeout
  import uar_cmd_parser_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LIMIT = '1
)(
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear || !run) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

  assign expire = run && (r_cnt == LIMIT);

endmodule

// File: rtl/uar_cmd_parser.sv
// Host-link command parser: hunts for SYNC, collects CMD + 4 data bytes + checksum
// and issues one 32-bit register write per good packet, with error reporting.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | hunting for the sync byte
// S_CMD   | waiting for the command byte (addr + write bit)
// S_DATA  | collecting D0..D3, LSB first
// S_CSUM  | waiting for the checksum byte
// S_ISSUE | holding the write request until wr_ready
module uar_cmd_parser
  import uar_cmd_parser_pkg::*;
#(
  parameter real         CLK_FREQ      = 100.0e6,
  parameter real         BAUD_RATE     = 115200.0,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_BYTES = 4
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_ferr,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] pkt_count,
  output logic        busy
);

  // Ten bit-times per byte on the line; truncated toward zero.
  localparam logic [TIMER_W-1:0] TO_LIMIT =
    TIMER_W'($rtoi(real'(TIMEOUT_BYTES) * 10.0 * CLK_FREQ / BAUD_RATE));

  state_e      r_state;
  logic [1:0]  r_idx;
  logic [7:0]  r_sum;
  logic        r_cmd_wr;
  logic        r_wr_valid;
  logic [6:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_err;
  err_code_e   r_err_code;
  logic [15:0] r_pkt_count;

  logic        w_run;
  logic        w_clear;
  logic        w_expire;
  logic [7:0]  w_sum_next;

  assign w_run      = in_packet(r_state);
  assign w_clear    = in_valid || in_ferr;
  assign w_sum_next = r_sum + in_data;

  uar_cmd_parser_byte_timeout #(
    .LIMIT (TO_LIMIT)
  ) u_byte_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (w_clear),
    .run    (w_run),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_sum       <= 8'd0;
      r_cmd_wr    <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 32'd0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_pkt_count <= 16'd0;
    end else begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;

      // The if/else chain encodes error priority; a framing error drops any coincident byte.
      if (in_ferr) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_FRAMING;
        if (w_run) r_state <= S_IDLE;
      end else if (w_expire && !in_valid) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
        r_state    <= S_IDLE;
      end else if (in_valid) begin
        case (r_state)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) r_state <= S_CMD;
          end
          S_CMD: begin
            r_wr_addr <= in_data[6:0];
            r_cmd_wr  <= in_data[7];
            r_sum     <= in_data;
            r_idx     <= 2'd0;
            r_state   <= S_DATA;
          end
          S_DATA: begin
            r_wr_data[8*r_idx +: 8] <= in_data;
            r_sum <= w_sum_next;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_CSUM;
          end
          S_CSUM: begin
            if (w_sum_next != 8'd0) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CHECKSUM;
              r_state    <= S_IDLE;
            end else if (!r_cmd_wr) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_BAD_CMD;
              r_state    <= S_IDLE;
            end else begin
              r_wr_valid <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVERRUN;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // The pending write completes regardless of errors reported while issuing.
      if ((r_state == S_ISSUE) && r_wr_valid && wr_ready) begin
        r_wr_valid  <= 1'b0;
        r_pkt_count <= r_pkt_count + 16'd1;
        r_state     <= S_IDLE;
      end
    end
  end

  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign pkt_count = r_pkt_count;
  assign busy      = (r_state != S_IDLE);

endmodule
